// File: rtl/conware_gen_ctrl.sv
// rtl/conware_gen_ctrl.sv - Game-of-Life frame pipeline sequencer (load, N generation steps, send)
//
// Sequences one frame through the conware datapath: enables the ingest buffer,
// issues num_gens generation-step strobes spaced STEP_LAT+1 cycles apart so the
// combinational generation block can settle, then enables the egress buffer and
// pulses done when it has sent the last beat.
//
// Optional build macro: CONWARE_AUTORUN_EN
//   defined   - DONE loops straight back to LOAD (num_gens re-latched, gen_count
//               cleared); only abort or reset returns the FSM to IDLE.
//   undefined - DONE returns to IDLE; one frame per accepted start.
//
// Parameters:
//   GEN_W     width of num_gens / gen_count
//   STEP_LAT  idle cycles after each step strobe (0..15)
//   FRAME_W   width of frame_count
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin one frame (sampled in IDLE only)
//   abort        cancel the current frame, return to IDLE
//   num_gens     generations per frame, latched on accepted start
//   load_en      ingest buffer may accept beats
//   load_done    ingest buffer accepted its last beat (1-cycle pulse)
//   step         generation-step strobe (1 cycle)
//   send_en      egress buffer may stream
//   send_done    egress buffer sent its last beat (1-cycle pulse)
//   busy         FSM is not in IDLE
//   done         frame completed (1-cycle pulse)
//   gen_count    steps issued in the current/last frame
//   frame_count  frames completed since reset (wraps)

module conware_gen_ctrl #(
    parameter int GEN_W    = 8,
    parameter int STEP_LAT = 2,
    parameter int FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [GEN_W-1:0]   num_gens,
    output logic               load_en,
    input  logic               load_done,
    output logic               step,
    output logic               send_en,
    input  logic               send_done,
    output logic               busy,
    output logic               done,
    output logic [GEN_W-1:0]   gen_count,
    output logic [FRAME_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [GEN_W-1:0]   GEN_ONE     = {{(GEN_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_W-1:0] FRAME_ONE   = {{(FRAME_W-1){1'b0}}, 1'b1};
    // Last value of the settle counter before leaving SETTLE; SETTLE is never
    // entered when STEP_LAT is 0, so the fallback value is irrelevant.
    localparam logic [3:0]         SETTLE_LAST = (STEP_LAT > 0) ? 4'(STEP_LAT - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [GEN_W-1:0]   num_gens_q, num_gens_d;
    logic [GEN_W-1:0]   gen_count_q, gen_count_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    logic [3:0]         settle_q, settle_d;
    logic [GEN_W-1:0]   gen_count_inc;

    assign gen_count_inc = gen_count_q + GEN_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            num_gens_q    <= '0;
            gen_count_q   <= '0;
            frame_count_q <= '0;
            settle_q      <= '0;
        end else begin
            state_q       <= state_d;
            num_gens_q    <= num_gens_d;
            gen_count_q   <= gen_count_d;
            frame_count_q <= frame_count_d;
            settle_q      <= settle_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        num_gens_d    = num_gens_q;
        gen_count_d   = gen_count_q;
        frame_count_d = frame_count_q;
        settle_d      = settle_q;

        case (state_q)
            S_IDLE: begin
                // abort outranks start even though it has nothing to cancel here
                if (start && !abort) begin
                    num_gens_d  = num_gens;
                    gen_count_d = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    state_d = (num_gens_q == '0) ? S_SEND : S_STEP;
                end
            end
            S_STEP: begin
                // The strobe is on the wire this cycle, so it is counted even
                // if abort cuts the frame short right now.
                gen_count_d = gen_count_inc;
                settle_d    = '0;
                if (STEP_LAT == 0) begin
                    state_d = (gen_count_inc == num_gens_q) ? S_SEND : S_STEP;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = (gen_count_q == num_gens_q) ? S_SEND : S_STEP;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SEND: begin
                if (send_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // done is already visible this cycle, so the frame is counted
                // regardless of a coincident abort.
                frame_count_d = frame_count_q + FRAME_ONE;
`ifdef CONWARE_AUTORUN_EN
                if (!abort) begin
                    num_gens_d  = num_gens;
                    gen_count_d = '0;
                end
                state_d = S_LOAD;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign load_en     = (state_q == S_LOAD);
    assign step        = (state_q == S_STEP);
    assign send_en     = (state_q == S_SEND);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign gen_count   = gen_count_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/conware_gen_ctrl.md
Name: conware_gen_ctrl

Overview:
- Sequencer for the Game-of-Life frame pipeline: AXIS ingest buffer -> combinational generation block -> colour mapper -> AXIS egress buffer.
- Enables frame ingest, then issues N generation-step strobes spaced to cover combinational settle time, then enables frame egress and reports completion.
- One instance sits beside the datapath inside the conware top level and drives its enables.

Parameters:
- GEN_W, 8, width of generation count request/status.
- STEP_LAT, 2, idle cycles after each step strobe before the next strobe or egress (0..15).
- FRAME_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one frame; sampled only in IDLE.
- abort  in  1  cancel the current frame.
- num_gens  in  GEN_W  generations per frame, latched when start is accepted.
- load_en  out  1  ingest buffer may accept AXIS beats.
- load_done  in  1  1-cycle pulse: ingest buffer accepted TLAST.
- step  out  1  1-cycle strobe: state register captures next generation.
- send_en  out  1  egress buffer may stream.
- send_done  in  1  1-cycle pulse: egress buffer sent TLAST.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse at frame completion.
- gen_count  out  GEN_W  steps issued in the current frame.
- frame_count  out  FRAME_W  frames completed since reset.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; load_en, step, send_en, busy, done = 0; gen_count=0; frame_count=0; latched num_gens=0; settle counter=0.
- Outputs are Moore-decoded from registered state/counters; no combinational input-to-output path.
- FSM states: IDLE, LOAD, STEP, SETTLE, SEND, DONE.
- IDLE: on start=1, latch num_gens, clear gen_count, go to LOAD. load_en rises the cycle after start.
- LOAD: load_en=1. On load_done, go to SEND if latched num_gens==0, else to STEP.
- STEP: step=1 for exactly one cycle; gen_count increments. Next state is SETTLE if STEP_LAT>0. If STEP_LAT=0, next state is SEND when the new gen_count equals latched num_gens, else STEP again (back-to-back strobes).
- SETTLE: counts STEP_LAT cycles. Then go to SEND if gen_count==latched num_gens, else STEP.
- Resulting strobe period: STEP_LAT+1 cycles.
- SEND: send_en=1. On send_done, go to DONE.
- DONE: done=1 for one cycle; frame_count increments (wraps modulo 2^FRAME_W); return to IDLE. gen_count holds its final value until the next accepted start.
- start while busy: ignored; the num_gens latch is unaffected.
- load_done outside LOAD and send_done outside SEND: ignored.
- abort in any non-IDLE state: go to IDLE next cycle. All enables deassert, no done pulse, frame_count unchanged, gen_count holds. abort in IDLE: no effect.
- abort has priority over load_done, send_done and start in the same cycle.
- num_gens=2^GEN_W-1: exact count issued; gen_count never wraps within a frame.
- Reset mid-frame: all outputs clear asynchronously. A downstream partial frame is the buffers' responsibility (they share rst).

Optional Feature:
- Macro: CONWARE_AUTORUN_EN.
- Defined: DONE transitions to LOAD instead of IDLE. num_gens is re-latched on that transition and gen_count cleared. busy stays high continuously. Only abort or reset returns the FSM to IDLE. start matters only from IDLE.
- Undefined: DONE -> IDLE as specified above; one frame per start.

Test Plan:
- STEP_LAT=2, num_gens=3, start; load_done 10 cycles later; send_done 20 cycles into SEND -> exactly 3 step pulses spaced 3 cycles apart, gen_count=3, done pulse 1 cycle after send_done, frame_count=1.
- num_gens=0 -> zero step pulses; send_en asserts the cycle after load_done; done follows send_done.
- STEP_LAT=0, num_gens=4 -> step high 4 consecutive cycles, then send_en.
- abort during SETTLE after 2 of 5 steps -> IDLE next cycle, busy=0, gen_count=2, no done, frame_count unchanged.
- abort and send_done in the same cycle -> abort wins: no done, frame_count unchanged. start during SEND -> ignored. load_done while in IDLE -> no state change.
- CONWARE_AUTORUN_EN defined, num_gens=1 -> after done, load_en reasserts next cycle with busy never dropping; frame_count counts 1, 2, 3 over three frames. rst pulled low mid-STEP -> all outputs 0 immediately.
